// File: rtl/bus_ram.sv
// Single-port word RAM behind a start/ready bus handshake with a fixed number
// of wait states, byte enables and address/alignment error responses.
module bus_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_strobe,
    output logic        ready,
    output logic        response,
    output logic [31:0] read_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    // One bit wider than the bus so BASE_ADDR + size cannot wrap at the top of the map
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    state_t             state_next;
    logic [3:0]         counter;
    logic               accept;
    logic               complete;
    logic               write_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         strobe_q;
    logic               in_range;
    logic               access_err;
    logic [IDX_W-1:0]   word_idx;
    logic [31:0]        mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (counter == 4'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready    = (state == IDLE);
        accept   = (state == IDLE) && start;
        complete = (state == BUSY) && (counter == 4'd0);
    end

    assign in_range   = ({1'b0, addr_q} >= {1'b0, BASE_ADDR}) && ({1'b0, addr_q} < LIMIT);
    assign access_err = !in_range || (addr_q[1:0] != 2'b00);
    assign word_idx   = addr_q[IDX_W+1:2];

    // Request capture needs no reset: it is only consumed after an accepted start
    always_ff @(posedge clock) begin
        if (accept) begin
            write_q  <= write;
            addr_q   <= address;
            wdata_q  <= write_data;
            strobe_q <= write_strobe;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            counter <= 4'd0;
        end else if (accept) begin
            counter <= 4'(WAIT_STATES);
        end else if ((state == BUSY) && (counter != 4'd0)) begin
            counter <= counter - 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            response  <= 1'b0;
            read_data <= 32'd0;
        end else if (complete) begin
            if (access_err) begin
                response  <= 1'b1;
                read_data <= 32'd0;
            end else begin
                response <= 1'b0;
                if (!write_q) begin
                    read_data <= mem[word_idx];
                end
            end
        end
    end

    // Reset on the completion edge aborts the write
    always_ff @(posedge clock) begin
        if (complete && !reset && !access_err && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (strobe_q[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_ram.sv
// Randomized bench for bus_ram: three instances (1, 0 and 15 wait states) share
// one stimulus stream and are compared every cycle against a transaction-level model.
module tb_bus_ram;

    localparam int NI = 3;
    localparam int WS [NI] = '{1, 0, 15};
    localparam longint unsigned BASE = 64'h0;
    localparam longint unsigned SIZE = 64'd4096;

    logic        clock;
    logic        reset;
    logic        start;
    logic        write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  write_strobe;
    logic [NI-1:0] rdy;
    logic [NI-1:0] resp;
    logic [31:0] rdat [NI];

    int n_checks = 0;
    int n_fail   = 0;

    bus_ram #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1)) dut_ws1 (
        .clock(clock), .reset(reset), .start(start), .write(write), .address(address),
        .write_data(write_data), .write_strobe(write_strobe),
        .ready(rdy[0]), .response(resp[0]), .read_data(rdat[0]));

    bus_ram #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut_ws0 (
        .clock(clock), .reset(reset), .start(start), .write(write), .address(address),
        .write_data(write_data), .write_strobe(write_strobe),
        .ready(rdy[1]), .response(resp[1]), .read_data(rdat[1]));

    bus_ram #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(15)) dut_ws15 (
        .clock(clock), .reset(reset), .start(start), .write(write), .address(address),
        .write_data(write_data), .write_strobe(write_strobe),
        .ready(rdy[2]), .response(resp[2]), .read_data(rdat[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model: per-instance memory with a per-byte "known" mask, plus the
    // pending transaction and the edge number at which it completes.
    logic [31:0] m_mem   [NI][1024];
    logic [3:0]  m_known [NI][1024];
    bit          m_busy  [NI];
    longint      m_done  [NI];
    logic        q_w     [NI];
    logic [31:0] q_a     [NI];
    logic [31:0] q_d     [NI];
    logic [3:0]  q_s     [NI];
    logic        e_resp  [NI];
    logic [31:0] e_rd    [NI];
    logic [31:0] e_mask  [NI];
    longint      edge_n = 0;
    bit          chk_en = 0;

    initial begin
        for (int k = 0; k < NI; k++) begin
            m_busy[k] = 0;
            for (int i = 0; i < 1024; i++) m_known[k][i] = 4'h0;
        end
    end

    task automatic model_complete(input int k);
        longint unsigned a;
        int idx;
        a = longint'(q_a[k]);
        idx = int'(q_a[k][11:2]);
        if (a < BASE || a >= BASE + SIZE || q_a[k][1:0] != 2'b00) begin
            e_resp[k] = 1'b1;
            e_rd[k]   = 32'd0;
            e_mask[k] = 32'hFFFF_FFFF;
        end else if (q_w[k]) begin
            e_resp[k] = 1'b0;
            for (int b = 0; b < 4; b++) begin
                if (q_s[k][b]) begin
                    m_mem[k][idx][8*b +: 8] = q_d[k][8*b +: 8];
                    m_known[k][idx][b] = 1'b1;
                end
            end
        end else begin
            e_resp[k] = 1'b0;
            e_rd[k]   = m_mem[k][idx];
            for (int b = 0; b < 4; b++) e_mask[k][8*b +: 8] = {8{m_known[k][idx][b]}};
        end
    endtask

    always @(posedge clock) begin
        edge_n++;
        for (int k = 0; k < NI; k++) begin
            if (reset) begin
                m_busy[k] = 0;
                e_resp[k] = 1'b0;
                e_rd[k]   = 32'd0;
                e_mask[k] = 32'hFFFF_FFFF;
            end else if (!m_busy[k]) begin
                if (start) begin
                    m_busy[k] = 1;
                    m_done[k] = edge_n + WS[k] + 1;
                    q_w[k] = write;
                    q_a[k] = address;
                    q_d[k] = write_data;
                    q_s[k] = write_strobe;
                end
            end else if (edge_n == m_done[k]) begin
                model_complete(k);
                m_busy[k] = 0;
            end
        end
        if (reset) chk_en = 1;
    end

    always @(negedge clock) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                check_value($sformatf("ready[%0d]", k), 32'(rdy[k]), 32'(!m_busy[k]));
                check_value($sformatf("response[%0d]", k), 32'(resp[k]), 32'(e_resp[k]));
                check_value($sformatf("read_data[%0d]", k), rdat[k] & e_mask[k], e_rd[k] & e_mask[k]);
            end
        end
    end

    // Issues one access from a negedge and returns at the negedge where every
    // instance is ready again; dup holds start (with junk fields) into BUSY.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit dup);
        int  low [NI];
        bit  all_rdy;
        write = w; address = a; write_data = d; write_strobe = s; start = 1'b1;
        for (int k = 0; k < NI; k++) low[k] = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (c == 0 && dup) begin
                address = a ^ 32'h40; write_data = ~d; write = ~w; write_strobe = 4'hF;
            end else begin
                start = 1'b0;
            end
            all_rdy = 1;
            for (int k = 0; k < NI; k++) begin
                if (!rdy[k]) begin
                    low[k]++;
                    all_rdy = 0;
                end
            end
            if (all_rdy) break;
        end
        for (int k = 0; k < NI; k++)
            check_value($sformatf("ready_low_cycles[%0d]", k), 32'(low[k]), 32'(WS[k] + 1));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int r;
        reset = 1'b1; start = 1'b0; write = 1'b0; address = 32'd0;
        write_data = 32'd0; write_strobe = 4'h0;
        repeat (3) @(negedge clock);
        check_value("reset_ready", 32'(rdy[0]), 32'd1);
        check_value("reset_response", 32'(resp[0]), 32'd0);
        check_value("reset_read_data", rdat[0], 32'd0);

        // First start in the same cycle reset drops
        reset = 1'b0;
        access(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
        check_value("wr10_resp", 32'(resp[0]), 32'd0);
        access(1'b0, 32'h10, 32'h0, 4'h0, 0);
        check_value("rd10_data", rdat[0], 32'hDEAD_BEEF);
        check_value("rd10_resp", 32'(resp[0]), 32'd0);

        access(1'b1, 32'h20, 32'h1122_3344, 4'hF, 0);
        access(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 1);
        access(1'b0, 32'h20, 32'h0, 4'h0, 0);
        check_value("rd20_merge", rdat[0], 32'h11BB_33DD);
        check_value("rd20_merge_ws15", rdat[2], 32'h11BB_33DD);
        access(1'b1, 32'h20, 32'h0, 4'b0000, 0);
        check_value("zero_strobe_resp", 32'(resp[0]), 32'd0);
        check_value("zero_strobe_rd_kept", rdat[0], 32'h11BB_33DD);
        access(1'b0, 32'h20, 32'h0, 4'h0, 1);
        check_value("rd20_after_zero_strobe", rdat[0], 32'h11BB_33DD);

        access(1'b1, 32'h0, 32'h0BAD_F00D, 4'hF, 0);
        access(1'b0, 32'h0000_1000, 32'h0, 4'h0, 0);
        check_value("oor_rd_resp", 32'(resp[0]), 32'd1);
        check_value("oor_rd_data", rdat[0], 32'd0);
        access(1'b0, 32'h0000_0002, 32'h0, 4'h0, 0);
        check_value("misalign_resp", 32'(resp[0]), 32'd1);
        check_value("misalign_data", rdat[0], 32'd0);
        access(1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 0);
        check_value("oor_wr_resp", 32'(resp[0]), 32'd1);
        access(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 0);
        check_value("top_of_map_resp", 32'(resp[0]), 32'd1);
        access(1'b0, 32'h0, 32'h0, 4'h0, 0);
        check_value("word0_unchanged", rdat[0], 32'h0BAD_F00D);
        check_value("word0_resp", 32'(resp[0]), 32'd0);

        // Reset lands on the completion edge of the 1-wait-state instance
        access(1'b1, 32'h30, 32'h5, 4'hF, 0);
        write = 1'b1; address = 32'h30; write_data = 32'h99; write_strobe = 4'hF; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        check_value("abort_ready", 32'(rdy[0]), 32'd1);
        check_value("abort_response", 32'(resp[0]), 32'd0);
        check_value("abort_ready_ws15", 32'(rdy[2]), 32'd1);
        access(1'b0, 32'h30, 32'h0, 4'h0, 0);
        check_value("abort_rd30", rdat[0], 32'h5);
        check_value("abort_rd30_ws15", rdat[2], 32'h5);

        for (int i = 0; i < 16; i++)
            access(1'b1, 32'h100 + 32'(4 * i), $urandom, 4'hF, 0);
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            a = 32'h100 + 32'(4 * $urandom_range(0, 15));
            if (r == 8) a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : 32'h1000 + 32'(4 * $urandom_range(0, 255));
            else if (r == 9) a = a | 32'($urandom_range(1, 3));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            access(1'($urandom_range(0, 1)), a, d, s, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_ram.md
BUS_RAM -- requirements
Module: bus_ram

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words stored; SHALL be a power of two, at least 4.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0; SHALL be aligned to DEPTH_WORDS*4.
REQ-003 Parameter WAIT_STATES, default 1, extra busy cycles per access; SHALL be in the range 0..15.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request strobe from the bus master; sampled only while ready=1.
REQ-007 write  input  1  1 = write access, 0 = read access; qualified by start.
REQ-008 address  input  32  byte address of the access; qualified by start.
REQ-009 write_data  input  32  write data; qualified by start and write.
REQ-010 write_strobe  input  4  byte enables for writes, bit n selects write_data[8n+7:8n]; ignored on reads.
REQ-011 ready  output  1  1 = idle and able to accept start, or previous access complete.
REQ-012 response  output  1  0 = RESP_OK, 1 = RESP_ERROR for the most recently completed access.
REQ-013 read_data  output  32  read result of the most recently completed read.

Function
REQ-014 The block SHALL implement the states IDLE and BUSY; ready SHALL be 1 exactly when the state is IDLE.
REQ-015 In IDLE with start=1, the block SHALL latch address, write, write_data and write_strobe, load the wait counter with WAIT_STATES, and enter BUSY on the next edge.
REQ-016 In BUSY with counter>0, the block SHALL decrement the counter and remain in BUSY.
REQ-017 In BUSY with counter=0, the block SHALL perform the access, update response and read_data, and return to IDLE on the same edge.
REQ-018 Latency: ready SHALL return to 1 exactly WAIT_STATES+1 cycles after the edge at which start was sampled.
REQ-019 start asserted while in BUSY SHALL be ignored, with no latching and no state change.
REQ-020 An access SHALL be in range when BASE_ADDR <= address < BASE_ADDR + DEPTH_WORDS*4, computed without overflow; the word index SHALL be address[log2(DEPTH_WORDS)+1:2].
REQ-021 An access SHALL be an error when it is out of range or address[1:0] != 2'b00.
REQ-022 An error access SHALL set response=1, leave memory unmodified, and set read_data=0.
REQ-023 An OK read SHALL set response=0 and read_data to the addressed word.
REQ-024 An OK write SHALL set response=0, update only the bytes whose write_strobe bit is 1, and leave read_data unchanged.
REQ-025 A write with write_strobe=4'b0000 SHALL complete as OK and modify no memory.
REQ-026 response and read_data SHALL remain stable from completion until the completion of the next accepted access; a master SHALL be able to sample read_data in any cycle after ready rises.
REQ-027 A read issued immediately after a write to the same word SHALL return the newly written value.
REQ-028 Memory contents SHALL NOT be initialised by reset; the contents of a never-written word are undefined.

Reset
REQ-029 While reset=1 at a clock edge, the block SHALL enter IDLE, with ready=1, response=0, read_data=0 and counter=0.
REQ-030 reset asserted while in BUSY SHALL abort the access; no memory write SHALL occur and start on that edge SHALL be ignored.
REQ-031 The first start SHALL be accepted on the first edge at which reset=0 and start=1.

Verification
REQ-032 Default parameters: write 32'hDEAD_BEEF, strobe 4'hF, to 32'h10, then read 32'h10 -> each access gives ready low for 2 cycles, response=0, and the read gives read_data=32'hDEAD_BEEF.
REQ-033 Write 32'h1122_3344 to 32'h20, then write 32'hAABB_CCDD with strobe 4'b0101, then read -> read_data=32'h11BB_33DD.
REQ-034 Read 32'h0000_1000 (out of range), then read 32'h0000_0002 (misaligned), then write 32'hFFFF_FFFF to 32'h0000_1000 -> each response=1, read_data=0, and a read of word 0 is unchanged.
REQ-035 WAIT_STATES=0 and WAIT_STATES=15 -> ready low for exactly 1 and exactly 16 cycles respectively; an extra start pulse during BUSY produces no second access.
REQ-036 Assert reset in the second BUSY cycle of a write to 32'h30 after a prior write of 32'h5 to 32'h30 -> ready=1 next cycle, response=0, and a later read of 32'h30 returns 32'h5.
